memory_fifo_controller: RTL

- Upstream stage for memory_module_32bit: turns a push/pop FIFO handshake into the memory's data/address/rE/wE strobes and captures its registered dataOut.
- The 32-entry memory behaves as a circular FIFO with a 5-bit read pointer and a 5-bit write pointer.
- The memory is single-ported, so at most one memory access is in flight at a time.

---
 rtl/memory_fifo_pkg.sv | 24 ++
 rtl/memory_fifo_controller_if.sv | 29 ++
 rtl/memory_module_32bit.sv | 21 ++
 rtl/memory_fifo_controller.sv | 118 +++++++++++
 4 files changed

// File: rtl/memory_fifo_pkg.sv
// Shared types and sizing for the memory-backed FIFO controller.
// Optional sticky misuse flag: define MEM_FIFO_ERROR_FLAG_EN.
package memory_fifo_pkg;

  localparam int DEPTH          = 32;
  localparam int PTR_WIDTH      = 5;
  localparam int DATA_WIDTH     = 8;
  localparam int MEM_ADDR_WIDTH = 6;
  localparam int CNT_WIDTH      = PTR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE
  } state_t;

  function automatic logic [MEM_ADDR_WIDTH-1:0] to_addr(
    input logic [PTR_WIDTH-1:0] p
  );
    return MEM_ADDR_WIDTH'(p);
  endfunction

endpackage

// File: rtl/memory_fifo_controller_if.sv
// Push/pop handshake and status bundle of the FIFO controller.
// master: the FIFO user; slave: the controller.
interface memory_fifo_controller_if;
  import memory_fifo_pkg::*;

  logic                  push;
  logic [DATA_WIDTH-1:0] pushData;
  logic                  pushReady;
  logic                  pop;
  logic                  popReady;
  logic [DATA_WIDTH-1:0] popData;
  logic                  popValid;
  logic                  full;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  count;

  modport master (
    output push, pushData, pop,
    input  pushReady, popReady, popData,
    input  popValid, full, empty, count
  );

  modport slave (
    input  push, pushData, pop,
    output pushReady, popReady, popData,
    output popValid, full, empty, count
  );

endinterface

// File: rtl/memory_module_32bit.sv
// Single-port memory: write on wE, registered read on rE.
// No reset; contents survive controller resets.
module memory_module_32bit
  import memory_fifo_pkg::*;
(
  input  logic                      clock,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic [MEM_ADDR_WIDTH-1:0] address,
  input  logic                      rE,
  input  logic                      wE,
  output logic [DATA_WIDTH-1:0]     dataOut
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (wE) mem[address] <= data;
    if (rE) dataOut <= mem[address];
  end

endmodule

// File: rtl/memory_fifo_controller.sv
// Circular FIFO over a single-port memory, one access in flight.
// Sticky misuse flag enabled by MEM_FIFO_ERROR_FLAG_EN.
module memory_fifo_controller
  import memory_fifo_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  memory_fifo_controller_if.slave   fifo,
  output logic [DATA_WIDTH-1:0]     memData,
  output logic [MEM_ADDR_WIDTH-1:0] memAddress,
  output logic                      memRE,
  output logic                      memWE,
  input  logic [DATA_WIDTH-1:0]     memDataOut,
  output logic                      error
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT =
    CNT_WIDTH'(DEPTH);

  state_t                 state;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]  pop_data;
  logic                   pop_valid;
  logic                   last_pop;
  logic                   full;
  logic                   empty;
  logic                   push_rdy;
  logic                   pop_rdy;
  logic                   do_push;
  logic                   do_pop;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign push_rdy = (state == IDLE) && !full;
  assign pop_rdy  = (state == IDLE) && !empty;

  // On a tie the side not served last time wins.
  assign do_push = fifo.push && push_rdy &&
                   !(fifo.pop && pop_rdy && !last_pop);
  assign do_pop  = fifo.pop && pop_rdy && !do_push;

  assign fifo.pushReady = push_rdy;
  assign fifo.popReady  = pop_rdy;
  assign fifo.popData   = pop_data;
  assign fifo.popValid  = pop_valid;
  assign fifo.full      = full;
  assign fifo.empty     = empty;
  assign fifo.count     = cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      pop_data   <= '0;
      pop_valid  <= 1'b0;
      memRE      <= 1'b0;
      memWE      <= 1'b0;
      memAddress <= '0;
      memData    <= '0;
      last_pop   <= 1'b1;
    end else begin
      pop_valid <= 1'b0;
      memRE     <= 1'b0;
      memWE     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (do_push) begin
            memData    <= fifo.pushData;
            memAddress <= to_addr(wr_ptr);
            memWE      <= 1'b1;
            wr_ptr     <= wr_ptr + PTR_WIDTH'(1);
            cnt        <= cnt + CNT_WIDTH'(1);
            last_pop   <= 1'b0;
            state      <= WRITE;
          end else if (do_pop) begin
            memAddress <= to_addr(rd_ptr);
            memRE      <= 1'b1;
            rd_ptr     <= rd_ptr + PTR_WIDTH'(1);
            cnt        <= cnt - CNT_WIDTH'(1);
            last_pop   <= 1'b1;
            state      <= READ;
          end
        end
        WRITE: state <= IDLE;
        READ:  state <= CAPTURE;
        CAPTURE: begin
          pop_data  <= memDataOut;
          pop_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_FIFO_ERROR_FLAG_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state == IDLE &&
                 ((fifo.push && full) ||
                  (fifo.pop && empty))) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule
